// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single off-chip memory port between instruction fetch and the data cache
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_adr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_inst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  localparam int CW = ($clog2(STARVE_LIM + 1) < 3) ? 3 : $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_inst_q, i_inst_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              gnt_d;
  // Arbitration, transaction sequencing and next values of every registered output
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    i_inst_d    = i_inst_q;
    d_rdata_d   = d_rdata_q;
    gnt_d       = d_req && (!i_req || starve_q < LIM);
    case (state_q)
      IDLE: begin
        if (gnt_d) begin
          state_d     = BUSY_D;
          mem_we_d    = d_we;
          mem_adr_d   = d_adr;
          mem_wdata_d = d_wdata;
          starve_d    = (i_req && starve_q != LIM) ? starve_q + 1'b1 : starve_q;
        end else if (i_req) begin
          state_d   = BUSY_I;
          mem_we_d  = 1'b0;
          mem_adr_d = i_adr;
          starve_d  = '0;
        end
      end
      BUSY_I: begin
        state_d  = mem_ready ? DONE_I : BUSY_I;
        i_inst_d = mem_ready ? mem_rdata : i_inst_q;
      end
      BUSY_D: begin
        state_d   = mem_ready ? DONE_D : BUSY_D;
        d_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : d_rdata_q;
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == BUSY_I) || (state_d == BUSY_D);
    i_ack_d   = state_d == DONE_I;
    d_ack_d   = state_d == DONE_D;
    busy_d    = state_d != IDLE;
  end
  // State and output registers; reset abandons any in-flight transaction without an ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      i_inst_q    <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      i_inst_q    <= i_inst_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_inst    = i_inst_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a behavioural memory and arbitration model
module tb_mem_arbiter;
  localparam int LIM = 4;
  logic        clk, rst_n;
  logic        i_req, i_ack, d_req, d_we, d_ack;
  logic [15:0] i_adr, i_inst, d_adr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_adr, mem_wdata, mem_rdata;
  logic        busy;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_inst(i_inst),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int min_w = 0, max_w = 0;
  bit hold = 0, stray = 0;

  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] iq [$];
  logic [15:0] dq [$];
  logic [15:0] i_last = 0, d_last = 0, d_exp_last = 0;
  logic [15:0] adr_prev = 0;
  logic        mreq_prev = 0;
  int          run = 0;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom(a);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred, none expected, at %0t", nm, $time);
  endtask

  // Memory responder: serves mem_req after a random wait, optionally pulses stray mem_ready
  initial begin
    int wcnt, tgt;
    mem_ready = 0;
    mem_rdata = 0;
    wcnt = 0;
    tgt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) mem_ready = 0;
      else if (mem_req && rst_n && !hold) begin
        if (wcnt == 0) tgt = $urandom_range(min_w, max_w);
        if (wcnt >= tgt) begin
          mem_ready = 1;
          if (mem_we) begin
            mem_arr[mem_adr] = mem_wdata;
            mem_rdata = 16'($urandom);
          end else mem_rdata = mem_arr.exists(mem_adr) ? mem_arr[mem_adr] : rom(mem_adr);
          wcnt = 0;
        end else wcnt++;
      end else begin
        wcnt = 0;
        if (stray && rst_n && !mem_req && $urandom_range(0, 2) == 0) begin
          mem_ready = 1;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on acks and checks each grant against the starvation rule
  always @(posedge clk) begin
    logic exp_d;
    #2;
    if (!rst_n) begin
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_mem_req", 16'(mem_req), 16'h0);
      chk("rst_mem_we", 16'(mem_we), 16'h0);
      chk("rst_mem_adr", mem_adr, 16'h0);
      chk("rst_mem_wdata", mem_wdata, 16'h0);
      chk("rst_acks", {14'h0, i_ack, d_ack}, 16'h0);
      chk("rst_i_inst", i_inst, 16'h0);
      chk("rst_d_rdata", d_rdata, 16'h0);
      iq.delete();
      dq.delete();
      i_last = 0;
      d_last = 0;
      run = 0;
      mreq_prev = 0;
    end else begin
      if (i_ack) begin
        if (iq.size() == 0) fail("i_ack_unexpected");
        else i_last = iq.pop_front();
      end
      if (d_ack) begin
        if (dq.size() == 0) fail("d_ack_unexpected");
        else d_last = dq.pop_front();
      end
      chk("i_inst", i_inst, i_last);
      chk("d_rdata", d_rdata, d_last);
      if (mem_req && !mreq_prev) begin
        if (!i_req && !d_req) fail("grant_without_request");
        else begin
          exp_d = d_req && (!i_req || run < LIM);
          chk("grant_adr", mem_adr, exp_d ? d_adr : i_adr);
          chk("grant_we", 16'(mem_we), exp_d ? 16'(d_we) : 16'h0);
          if (exp_d && d_we) chk("grant_wdata", mem_wdata, d_wdata);
          run = !exp_d ? 0 : (i_req && run < LIM) ? run + 1 : run;
        end
      end else if (mem_req) chk("hold_adr", mem_adr, adr_prev);
      mreq_prev = mem_req;
      adr_prev = mem_adr;
    end
  end

  task automatic i_txn(input logic [15:0] a);
    bit got = 0;
    i_adr = a;
    i_req = 1;
    iq.push_back(ref_rd(a));
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = i_ack;
    end
    if (!got) fail("i_ack_timeout");
    i_req = 0;
  endtask

  task automatic d_txn(input logic we, input logic [15:0] a, input logic [15:0] wd);
    bit got = 0;
    d_we = we;
    d_adr = a;
    d_wdata = wd;
    d_req = 1;
    if (we) ref_mem[a] = wd;
    else d_exp_last = ref_rd(a);
    dq.push_back(d_exp_last);
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = d_ack;
    end
    if (!got) fail("d_ack_timeout");
    d_req = 0;
  endtask

  task automatic i_stream(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      i_txn(16'($urandom_range(0, 255)));
    end
  endtask

  task automatic d_stream(input int n, input int maxgap, input int wpct);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      d_txn($urandom_range(0, 99) < wpct, 16'h0100 | 16'($urandom_range(0, 15)), 16'($urandom));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0;
    i_req = 0; i_adr = 0;
    d_req = 0; d_we = 0; d_adr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // single fetch with mem_ready in cycle 3
    min_w = 2; max_w = 2;
    mem_arr[16'h0003] = 16'h6F70;
    ref_mem[16'h0003] = 16'h6F70;
    i_adr = 16'h0003;
    i_req = 1;
    iq.push_back(16'h6F70);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #3;
      n++;
      if (i_ack) break;
    end
    chk("fetch_latency", 16'(n), 16'd4);
    chk("fetch_inst", i_inst, 16'h6F70);
    @(negedge clk);
    i_req = 0;
    @(posedge clk);
    #3;
    chk("fetch_busy_after", 16'(busy), 16'h0);
    @(negedge clk);
    // store then load
    min_w = 0; max_w = 3;
    d_txn(1, 16'h0100, 16'h0001);
    chk("store_rdata", d_rdata, 16'h0000);
    d_txn(0, 16'h0100, 16'h0000);
    chk("load_rdata", d_rdata, 16'h0001);
    // contention with zero-wait memory
    min_w = 0; max_w = 0;
    fork
      i_stream(12, 0);
      d_stream(40, 0, 50);
    join
    // data-only stream
    min_w = 0; max_w = 2;
    d_stream(20, 1, 50);
    // reset while in BUSY_D
    hold = 1;
    d_we = 0; d_adr = 16'h0105; d_req = 1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 16'(busy), 16'h1);
    rst_n = 0;
    d_req = 0;
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    d_exp_last = 0;
    chk("post_rst_mem_req", 16'(mem_req), 16'h0);
    chk("post_rst_busy", 16'(busy), 16'h0);
    repeat (4) @(negedge clk);
    chk("idle_after_rst", 16'(busy), 16'h0);
    d_txn(0, 16'h0105, 16'h0000);
    // random traffic with stray mem_ready pulses
    stray = 1;
    min_w = 0; max_w = 3;
    fork
      i_stream(80, 3);
      d_stream(80, 3, 50);
    join
    stray = 0;
    repeat (4) @(negedge clk);
    chk("final_i_queue", 16'(iq.size()), 16'h0);
    chk("final_d_queue", 16'(dq.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single off-chip memory port of the 16-bit MIPS between the instruction-fetch path (ROM/I-side miss, read-only) and the data cache (refill reads, write-through stores). It sits between the cache controllers and the DE2 off-chip memory interface. Only one transaction is outstanding at a time. Data requests win by default, and a starvation limit guarantees forward progress for instruction fetch.

## Interface
- ADDR_W, 16, address width on both requester ports and on the memory port
- DATA_W, 16, data/instruction word width
- STARVE_LIM, 4, consecutive data grants allowed while an instruction request is waiting
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low (one clock; reset is synchronous and active-low)
- i_req  input  1  instruction read request, held until i_ack
- i_adr  input  ADDR_W  instruction address, stable while i_req is high
- i_ack  output  1  one-cycle completion pulse; i_inst is valid in the same cycle
- i_inst  output  DATA_W  registered fetched word
- d_req  input  1  data request, held until d_ack
- d_we  input  1  1 = write, 0 = read; stable while d_req is high
- d_adr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_ack  output  1  one-cycle completion pulse
- d_rdata  output  DATA_W  registered load data
- mem_req  output  1  memory access strobe, held until mem_ready
- mem_we  output  1  memory write enable
- mem_adr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  read data, valid while mem_ready is high
- mem_ready  input  1  one-cycle completion from memory
- busy  output  1  high whenever the state is not IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: evaluates requests.
  - If d_req is high and (i_req is low or starve_cnt < STARVE_LIM), grant D. Latch d_we/d_adr/d_wdata into the mem_* registers. Go to BUSY_D.
  - Otherwise, if i_req is high, grant I. Latch i_adr, with mem_we=0. Go to BUSY_I.
- starve_cnt (3 bits minimum, saturating at STARVE_LIM):
  - Increments on a D grant while i_req is high.
  - Clears on any I grant.
  - Is unchanged on a D grant while i_req is low.
- BUSY_x: mem_req=1 with latched mem_adr/mem_we/mem_wdata held constant.
  - Stays in BUSY_x until mem_ready=1.
  - On mem_ready, mem_req drops to 0 in the next cycle.
  - For reads, mem_rdata is captured into i_inst or d_rdata.
  - For writes, d_rdata is unchanged.
  - Next state is DONE_x.
- DONE_x: pulse the matching ack for exactly one cycle, then return to IDLE.
  - The requester deasserts req after sampling ack.
  - Requests in DONE are not evaluated.
- mem_ready outside the BUSY states is ignored.
- Requester inputs are sampled only at grant. Changes while BUSY have no effect.
- Reset values, with rst_n=0 at any clock edge including mid-transaction:
  - state=IDLE, starve_cnt=0.
  - mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0.
  - i_ack=0, d_ack=0, i_inst=0, d_rdata=0, busy=0.
  - Any in-flight transaction is abandoned with no ack.

## Timing
- All outputs are registered.
- Cycle 0: request seen in IDLE.
- Cycle 1: mem_req=1.
- Cycle k: memory returns mem_ready=1 at some k ≥ 1.
- Cycle k+1: ack=1 and read data valid; mem_req=0.
- Cycle k+2: IDLE. A new request can be granted here.
- Minimum request-to-ack latency is 2 cycles (mem_ready in cycle 1).
- Back-to-back throughput: one transaction per k+2 cycles.
- A simultaneous i_req and d_req in the same IDLE cycle is resolved by the starvation rule; exactly one grant is issued.

## Test plan
- Single fetch: i_req with i_adr=0x0003, memory returns 0x6F70 with mem_ready in cycle 3 -> mem_adr=0x0003, mem_we=0 in cycles 1..3; i_ack with i_inst=0x6F70 in cycle 4; busy=0 in cycle 5.
- Store then load: d_req/d_we=1, d_adr=0x0100, d_wdata=0x0001 -> mem_we=1, mem_wdata=0x0001, d_ack after mem_ready, d_rdata still 0. Then a read of 0x0100 returning 0x0001 -> d_rdata=0x0001.
- Contention: i_req and d_req both held continuously, zero-wait memory -> grant order D,D,D,D,I,D,D,D,D,I…; starve_cnt never exceeds 4.
- Data-only stream: d_req repeatedly with i_req low -> starve_cnt stays 0, no I grants, no mem_req glitch between transactions.
- Reset mid-operation: rst_n=0 for one cycle while in BUSY_D -> next cycle mem_req=0, busy=0, no d_ack. A later request completes normally.
- Stray mem_ready: pulse mem_ready while in IDLE and DONE_I -> no state change, no ack, data registers unchanged.
